// File: rtl/mem_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb2 : two-master SRAM request arbiter with in-order read routing.   |
// | Define MEM_ARB2_ROUNDROBIN_EN for round-robin ties (default: m0 wins).   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mem_arb2 #(
  parameter int RDQ_LOG2 = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [29:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_writedatamask,
  input  logic [1:0]  m0_id,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic [1:0]  m0_readdataid,
  output logic        m0_readdatavalid,
  input  logic [29:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_writedatamask,
  input  logic [1:0]  m1_id,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [1:0]  m1_readdataid,
  output logic        m1_readdatavalid,
  output logic [29:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_writedatamask,
  output logic [1:0]  s_id,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  input  logic [1:0]  s_readdataid,
  input  logic        s_readdatavalid,
  output logic        rdq_err
);

  localparam int               c_DEPTH   = 1 << RDQ_LOG2;
  localparam logic [0:0]       c_IDLE    = 1'b0;
  localparam logic [0:0]       c_LOCKED  = 1'b1;
  localparam logic [RDQ_LOG2:0] c_PTR_ONE = {{RDQ_LOG2{1'b0}}, 1'b1};

  logic [0:0]        r_state;
  logic              r_owner;
  logic [RDQ_LOG2:0] r_wptr;
  logic [RDQ_LOG2:0] r_rptr;
  logic              r_rdq [c_DEPTH];
  logic              r_rdq_err;

  logic w_full, w_empty, w_elig0, w_elig1, w_tie_gnt;
  logic w_gnt, w_gnt_vld, w_sel_read, w_sel_write;
  logic w_accept, w_push, w_pop, w_head;

  // Full is judged on registered pointers, so a same-cycle pop cannot unblock a read.
  assign w_full  = (r_wptr[RDQ_LOG2] != r_rptr[RDQ_LOG2]) &&
                   (r_wptr[RDQ_LOG2-1:0] == r_rptr[RDQ_LOG2-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  assign w_elig0 = m0_write | (m0_read & ~w_full);
  assign w_elig1 = m1_write | (m1_read & ~w_full);

`ifdef MEM_ARB2_ROUNDROBIN_EN
  logic r_last;
  assign w_tie_gnt = ~r_last;
`else
  assign w_tie_gnt = 1'b0;
`endif

  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_vld = 1'b0;
    if (r_state == c_LOCKED) begin
      w_gnt     = r_owner;
      w_gnt_vld = r_owner ? w_elig1 : w_elig0;
    end else if (w_elig0 && w_elig1) begin
      w_gnt     = w_tie_gnt;
      w_gnt_vld = 1'b1;
    end else if (w_elig1) begin
      w_gnt     = 1'b1;
      w_gnt_vld = 1'b1;
    end else if (w_elig0) begin
      w_gnt     = 1'b0;
      w_gnt_vld = 1'b1;
    end
  end

  assign w_sel_read      = w_gnt ? m1_read  : m0_read;
  assign w_sel_write     = w_gnt ? m1_write : m0_write;
  assign s_address       = w_gnt ? m1_address       : m0_address;
  assign s_writedata     = w_gnt ? m1_writedata     : m0_writedata;
  assign s_writedatamask = w_gnt ? m1_writedatamask : m0_writedatamask;
  assign s_id            = w_gnt ? m1_id            : m0_id;
  assign s_read          = w_gnt_vld & w_sel_read & ~w_full;
  assign s_write         = w_gnt_vld & w_sel_write;

  assign m0_waitrequest  = (w_gnt_vld && !w_gnt) ? s_waitrequest : 1'b1;
  assign m1_waitrequest  = (w_gnt_vld &&  w_gnt) ? s_waitrequest : 1'b1;

  assign w_accept = w_gnt_vld & ~s_waitrequest;
  assign w_push   = s_read & ~s_waitrequest;
  assign w_pop    = s_readdatavalid & ~w_empty;
  assign w_head   = r_rdq[r_rptr[RDQ_LOG2-1:0]];

  assign m0_readdatavalid = w_pop & ~w_head;
  assign m1_readdatavalid = w_pop &  w_head;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdataid    = s_readdataid;
  assign m1_readdataid    = s_readdataid;
  assign rdq_err          = r_rdq_err;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_owner   <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rdq_err <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_gnt_vld && s_waitrequest) begin
            r_state <= c_LOCKED;
            r_owner <= w_gnt;
          end
        end
        c_LOCKED: begin
          if (!s_waitrequest) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
      if (s_readdatavalid && w_empty) r_rdq_err <= 1'b1;
    end
  end

`ifdef MEM_ARB2_ROUNDROBIN_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_last <= 1'b1;
    else if (w_accept) r_last <= w_gnt;
  end
`else
  logic w_accept_unused;
  assign w_accept_unused = w_accept;
`endif

  // Tracking slots hold only the issuing master; validity comes from the pointers.
  always_ff @(posedge clock) begin
    if (w_push) r_rdq[r_wptr[RDQ_LOG2-1:0]] <= w_gnt;
  end

endmodule
`default_nettype wire

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 SHALL have parameter RDQ_LOG2, default 2, meaning log2 of the outstanding-read tracking depth (4 entries).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have, per master N in {0,1}, mN_address in 30, mN_read in 1, mN_write in 1, mN_writedata in 32, mN_writedatamask in 4, mN_id in 2: request payload, held stable while mN_waitrequest=1.
REQ-005 SHALL have, per master, mN_waitrequest out 1, mN_readdata out 32, mN_readdataid out 2, mN_readdatavalid out 1: returned read data for that master only.
REQ-006 SHALL have slave ports s_address out 30, s_read out 1, s_write out 1, s_writedata out 32, s_writedatamask out 4, s_id out 2: muxed request to the SRAM controller.
REQ-007 SHALL have s_waitrequest in 1, s_readdata in 32, s_readdataid in 2, s_readdatavalid in 1: responses from the SRAM controller, in issue order.
REQ-008 SHALL have port rdq_err out 1: sticky flag, set on a read return with no outstanding read.

Function
REQ-009 SHALL track arbitration in states IDLE and LOCKED, with register owner (1 bit).
REQ-010 In IDLE, SHALL grant combinationally to the single requesting master; if both request, SHALL grant master 0 (see REQ-022).
REQ-011 SHALL drive s_* from the granted master, with s_read/s_write = 0 when no master requests.
REQ-012 SHALL give the non-granted master mN_waitrequest=1, and the granted master mN_waitrequest = s_waitrequest.
REQ-013 IDLE->LOCKED when the granted request is presented with s_waitrequest=1; owner SHALL latch the grant.
REQ-014 In LOCKED, SHALL present only owner's request, whatever the other master does; LOCKED->IDLE when s_waitrequest=0 (acceptance).
REQ-015 An accepted read (s_read & ~s_waitrequest) SHALL push the granted master index into a FIFO of depth 2**RDQ_LOG2.
REQ-016 With the FIFO full, SHALL mask any read: s_read=0, mN_waitrequest=1 for a reading master. Writes SHALL proceed and stay grantable to either master.
REQ-017 s_readdatavalid=1 with the FIFO non-empty SHALL pop the head and, in the same cycle, assert mH_readdatavalid for head master H, with mH_readdata=s_readdata and mH_readdataid=s_readdataid. Data SHALL pass through combinationally with 0 added latency.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged. With the FIFO full, a same-cycle pop SHALL NOT unblock the read in that cycle; the read is accepted next cycle at the earliest.
REQ-019 s_readdatavalid=1 with the FIFO empty SHALL assert no mN_readdatavalid and SHALL set rdq_err.
REQ-020 FIFO pointers SHALL be RDQ_LOG2+1 bits and wrap modulo 2**(RDQ_LOG2+1); full = MSBs differ and low bits equal.

Reset
REQ-021 While rst_n=0, SHALL be in IDLE with owner=0, FIFO empty, rdq_err=0, and mN_readdatavalid=0. Reset mid-transaction SHALL discard all outstanding-read tracking. rst_n SHALL be deasserted synchronously to clock by the integrator.

Configuration
REQ-022 With macro MEM_ARB2_ROUNDROBIN_EN defined, a both-request tie in IDLE SHALL go to the master not granted most recently (register last, reset 1, so master 0 wins first). Undefined: master 0 SHALL always win ties.

Verification
REQ-023 m0 read @0x100, m1 read @0x200 in the same cycle, s_waitrequest=0 -> m0 issued first, m1 next cycle. Returns route to m0 then m1, with readdataid preserved.
REQ-024 m1 write granted, s_waitrequest=1 for 3 cycles, m0 requesting -> s_address stays m1's for 4 cycles and m0_waitrequest=1 throughout; m0 is issued on the cycle after acceptance.
REQ-025 5 back-to-back m0 reads, no returns -> 4 accepted, 5th stalled. One return then arrives -> 5th accepted the following cycle. Interleaved m1 write accepted while full.
REQ-026 s_readdatavalid pulse after reset with no reads -> no mN_readdatavalid, rdq_err=1 and stays 1 until rst_n=0.
REQ-027 rst_n asserted with 2 reads outstanding -> FIFO empty. A late return then sets rdq_err and raises no master valid.
REQ-028 With MEM_ARB2_ROUNDROBIN_EN, both masters continuously issuing writes, s_waitrequest=0 -> grants alternate 0,1,0,1. Without the macro, all grants go to m0.
